spi_audio_rx: RTL and testbench
===============================

SPI_AUDIO_RX -- requirements
Module: spi_audio_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per audio word (8..32).
REQ-002 SHALL have parameter NUM_CH, default 2, meaning channels interleaved per CS frame (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk_25mhz, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have port com_sclk_in, input, 1, meaning SPI clock from the Pico, asynchronous to clk_25mhz, at most clk/4.
REQ-007 SHALL have port com_mosi_in, input, 1, meaning SPI data, MSB first, valid at the com_sclk_in rising edge.
REQ-008 SHALL have port com_active, input, 1, meaning active-high frame select.
REQ-009 SHALL have port out_data, output, DATA_W, meaning the word at the FIFO head.
REQ-010 SHALL have port out_ch, output, $clog2(NUM_CH) (min 1), meaning the channel index of out_data.
REQ-011 SHALL have port out_valid, output, 1, meaning the FIFO is non-empty.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer accepts the head word.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH+1), meaning the entries held.
REQ-014 SHALL have port frame_err, output, 1, meaning a one-cycle pulse on an aborted partial word.
REQ-015 SHALL have port overrun, output, 1, meaning sticky: a completed word was dropped because the FIFO was full.

Function
REQ-016 SHALL pass com_sclk_in, com_mosi_in and com_active each through a 2-flop synchronizer, then detect edges with one further register.
REQ-017 SHALL shift the synchronized mosi into the shift register MSB-first on each detected sclk rising edge, only while synchronized com_active=1.
REQ-018 SHALL clear the bit counter and the channel index to 0 on a detected com_active rising edge.
REQ-019 SHALL, on bit counter reaching DATA_W, push {ch, word} into the FIFO, reset the bit counter, and advance ch modulo NUM_CH, all in the same cycle.
REQ-020 SHALL present out_valid=1 on the 4th clk rising edge after the final sclk rising edge of a word when the FIFO was empty, i.e. 2 sync + 1 edge + 1 write.
REQ-021 SHALL pop the head on a cycle with out_valid=1 and out_ready=1; out_data/out_ch shall then show the next entry or hold the last value when empty.
REQ-022 SHALL, on a push with FIFO full and no pop, drop the word, set overrun=1, and leave the FIFO contents unchanged.
REQ-023 SHALL accept a simultaneous push and pop when full, leaving level unchanged and overrun unchanged.
REQ-024 SHALL treat a simultaneous push and pop when empty as a push only; out_ready is ignored while out_valid=0.
REQ-025 SHALL, on a detected com_active falling edge with bit counter non-zero, discard the partial word, pulse frame_err for one cycle, and push nothing.
REQ-026 SHALL ignore sclk edges while com_active=0; a falling edge at bit counter 0 is not an error.
REQ-027 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH, with level derived so that full and empty are distinct.

Reset
REQ-028 SHALL, while reset=1, asynchronously force: out_valid=0, out_data=0, out_ch=0, fifo_level=0, frame_err=0, overrun=0, synchronizers=0, bit counter=0, ch=0.
REQ-029 SHALL discard a word in progress when reset asserts mid-frame; after release, reception resumes only at the next com_active rising edge.

Structure
REQ-030 SHALL place the default DATA_W/NUM_CH/FIFO_DEPTH constants and the FIFO entry struct {ch, data} in shared package spi_audio_pkg.
REQ-031 SHALL implement the buffer as one sub-module, sync_fifo, parameterised on width and depth, and instantiated once.

Verification
REQ-032 SHALL test: a frame with one word 16'hC0DE -> out_valid 4 cycles after the last sclk edge, out_data=16'hC0DE, out_ch=0.
REQ-033 SHALL test: a frame with 16'h1234, 16'hABCD, 16'h5555 and NUM_CH=2 -> pops (0,1234), (1,ABCD), (0,5555).
REQ-034 SHALL test: out_ready=0 while 5 words are sent with FIFO_DEPTH=4 -> fifo_level=4, overrun=1, and the pops yield only the first 4 words.
REQ-035 SHALL test: com_active dropped after 9 bits -> frame_err pulses once with no push; the next frame 16'hBEEF is received intact with ch=0.
REQ-036 SHALL test: reset asserted after 7 bits -> all outputs 0 immediately, and the next frame 16'h0F0F is received correctly.
REQ-037 SHALL test: DATA_W=24 with word 24'hA5C3E1 -> out_data=24'hA5C3E1.

Source files
------------

// File: rtl/spi_audio_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_audio_pkg
//  Description : Shared defaults, FIFO entry layout and width helper for the
//                SPI audio receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_audio_pkg;

    localparam int C_DATA_W     = 16;
    localparam int C_NUM_CH     = 2;
    localparam int C_FIFO_DEPTH = 4;

    // Entry fields are sized for the largest legal configuration so that one
    // struct serves every parameterisation; unused upper bits stay zero.
    localparam int C_MAX_DATA_W = 32;
    localparam int C_MAX_CH_W   = 3;

    typedef struct packed {
        logic [C_MAX_CH_W-1:0]   ch;
        logic [C_MAX_DATA_W-1:0] data;
    } fifo_entry_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with a registered head word. The head holds
//                its last value once the FIFO drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_empty,
    output logic                           o_full,
    output logic [$clog2(DEPTH+1)-1:0]     o_level
);

    localparam int C_ADDR_W = $clog2(DEPTH);
    localparam int C_LVL_W  = $clog2(DEPTH+1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [C_ADDR_W-1:0] r_wr_ptr;
    logic [C_ADDR_W-1:0] r_rd_ptr;
    logic [C_LVL_W-1:0]  r_level;
    logic [WIDTH-1:0]    r_head;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == C_LVL_W'(DEPTH));
    assign o_level   = r_level;
    assign o_rdata   = r_head;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when a pop frees the slot in the same cycle.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Storage array; contents need no reset because the head register masks them.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_ADDR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_ADDR_W'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + C_LVL_W'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - C_LVL_W'(1);
            end
        end
    end

    // Head word: take the incoming word when it becomes the only entry,
    // otherwise advance to the next stored entry on a pop, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
        end else if (w_push_ok && ((r_level == '0) || ((r_level == C_LVL_W'(1)) && w_pop_ok))) begin
            r_head <= i_wdata;
        end else if (w_pop_ok && (r_level > C_LVL_W'(1))) begin
            r_head <= r_mem[r_rd_ptr + C_ADDR_W'(1)];
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_audio_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_audio_rx
//  Description : SPI slave receiver for interleaved audio words. Inputs are
//                synchronised into clk_25mhz, words are assembled MSB first
//                and tagged with a channel index, then buffered in a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_audio_rx
    import spi_audio_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W,
    parameter int NUM_CH     = C_NUM_CH,
    parameter int FIFO_DEPTH = C_FIFO_DEPTH
) (
    input  logic                              clk_25mhz,
    input  logic                              reset,
    input  logic                              com_sclk_in,
    input  logic                              com_mosi_in,
    input  logic                              com_active,
    output logic [DATA_W-1:0]                 out_data,
    output logic [ch_width(NUM_CH)-1:0]       out_ch,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              frame_err,
    output logic                              overrun
);

    localparam int C_CH_W  = ch_width(NUM_CH);
    localparam int C_CNT_W = $clog2(DATA_W+1);

    logic [1:0]         r_sclk_sync;
    logic [1:0]         r_mosi_sync;
    logic [1:0]         r_act_sync;
    logic               r_sclk_d;
    logic               r_act_d;
    logic [1:0]         r_warm;
    logic               r_armed;
    logic               r_in_frame;
    logic [DATA_W-1:0]  r_shift;
    logic [C_CNT_W-1:0] r_bit_cnt;
    logic [C_CH_W-1:0]  r_ch;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_sclk_rise;
    logic               w_act_rise;
    logic               w_act_fall;
    logic               w_shift_en;
    logic               w_push;
    logic               w_pop;
    logic               w_abort;
    logic               w_empty;
    logic               w_full;
    fifo_entry_t        w_push_entry;
    fifo_entry_t        w_head;
    logic               w_head_unused;

    // Two-flop synchronisers followed by one edge-detect register per line.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_act_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_act_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], com_sclk_in};
            r_mosi_sync <= {r_mosi_sync[0], com_mosi_in};
            r_act_sync  <= {r_act_sync[0], com_active};
            r_sclk_d    <= r_sclk_sync[1];
            r_act_d     <= r_act_sync[1];
        end
    end

    // After reset, frames are accepted only once the select line has been seen
    // idle, so a frame already in flight at reset release is ignored entirely.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_warm  <= '0;
            r_armed <= 1'b0;
        end else begin
            if (r_warm != 2'd2) begin
                r_warm <= r_warm + 2'd1;
            end
            if ((r_warm == 2'd2) && !r_act_sync[1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_act_rise  = r_act_sync[1] & ~r_act_d & r_armed;
    assign w_act_fall  = ~r_act_sync[1] & r_act_d;
    assign w_shift_en  = w_sclk_rise & r_in_frame & r_act_sync[1];
    assign w_push      = (r_bit_cnt == C_CNT_W'(DATA_W));
    assign w_abort     = w_act_fall & r_in_frame & (r_bit_cnt != '0) & ~w_push;
    assign w_pop       = out_ready & out_valid;

    // Frame membership: opened by an accepted select rise, closed when select drops.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_in_frame <= 1'b0;
        end else if (w_act_rise) begin
            r_in_frame <= 1'b1;
        end else if (!r_act_sync[1]) begin
            r_in_frame <= 1'b0;
        end
    end

    // Word assembly: shift register, bit counter and channel index.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ch      <= '0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {r_shift[DATA_W-2:0], r_mosi_sync[1]};
            end

            if (w_act_rise || w_act_fall) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= w_push ? C_CNT_W'(1) : r_bit_cnt + C_CNT_W'(1);
            end else if (w_push) begin
                r_bit_cnt <= '0;
            end

            if (w_act_rise) begin
                r_ch <= '0;
            end else if (w_push) begin
                r_ch <= (r_ch == C_CH_W'(NUM_CH-1)) ? '0 : r_ch + C_CH_W'(1);
            end
        end
    end

    // Status flags: one-cycle abort pulse and sticky drop indication.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_abort;
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Pack the completed word and its channel into the shared entry layout.
    always_comb begin
        w_push_entry      = '0;
        w_push_entry.ch   = C_MAX_CH_W'(r_ch);
        w_push_entry.data = C_MAX_DATA_W'(r_shift);
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_25mhz),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    assign out_valid     = ~w_empty;
    assign out_data      = w_head.data[DATA_W-1:0];
    assign out_ch        = w_head.ch[C_CH_W-1:0];
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;
    // Upper entry bits are zero padding for narrow configurations.
    assign w_head_unused = ^w_head;

endmodule
`default_nettype wire

// File: tb/tb_spi_audio_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_audio_rx
//  Description : Self-checking bench for spi_audio_rx (16-bit and 24-bit
//                instances) using a scoreboard of expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_audio_rx;

    logic        tb_clk_25mhz = 1'b0;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        act16;
    logic        act24;
    logic        rdy16;
    logic        rdy24;

    logic [15:0] data16;
    logic [0:0]  ch16;
    logic        v16;
    logic [2:0]  lvl16;
    logic        fe16;
    logic        ov16;

    logic [23:0] data24;
    logic [0:0]  ch24;
    logic        v24;
    logic [2:0]  lvl24;
    logic        fe24;
    logic        ov24;

    typedef struct {
        logic [31:0] data;
        logic [31:0] ch;
    } exp_t;

    exp_t sb16[$];
    exp_t sb24[$];
    int   ch_model;
    int   n_total = 0;
    int   n_bad   = 0;

    always #20 tb_clk_25mhz = ~tb_clk_25mhz;

    spi_audio_rx #(.DATA_W(16), .NUM_CH(2), .FIFO_DEPTH(4)) dut16 (
        .clk_25mhz   (tb_clk_25mhz),
        .reset       (reset),
        .com_sclk_in (sclk),
        .com_mosi_in (mosi),
        .com_active  (act16),
        .out_data    (data16),
        .out_ch      (ch16),
        .out_valid   (v16),
        .out_ready   (rdy16),
        .fifo_level  (lvl16),
        .frame_err   (fe16),
        .overrun     (ov16)
    );

    spi_audio_rx #(.DATA_W(24), .NUM_CH(2), .FIFO_DEPTH(4)) dut24 (
        .clk_25mhz   (tb_clk_25mhz),
        .reset       (reset),
        .com_sclk_in (sclk),
        .com_mosi_in (mosi),
        .com_active  (act24),
        .out_data    (data24),
        .out_ch      (ch24),
        .out_valid   (v24),
        .out_ready   (rdy24),
        .fifo_level  (lvl24),
        .frame_err   (fe24),
        .overrun     (ov24)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge tb_clk_25mhz);
        #7;
    endtask

    // One SPI bit: 8 system clocks per SCLK period; optionally count clock
    // edges from the SCLK rise until out_valid appears on the 16-bit DUT.
    task automatic spi_bit(input logic b, input bit measure, output int lat);
        lat  = -1;
        mosi = b;
        #80;
        sclk = 1'b1;
        if (measure) begin
            for (int k = 1; k <= 8; k++) begin
                @(posedge tb_clk_25mhz);
                #1;
                if (v16 && lat < 0) lat = k;
            end
            #6;
        end else begin
            #160;
        end
        sclk = 1'b0;
        #80;
    endtask

    task automatic send_word(input int which, input logic [31:0] w, input int nbits,
                             input bit keep, input bit measure);
        int   lat;
        exp_t e;
        lat = -1;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(w[i], measure && (i == 0), lat);
        end
        if (measure) check_val("latency", lat, 4);
        if (nbits == ((which != 0) ? 24 : 16)) begin
            e.data = w;
            e.ch   = ch_model;
            if (keep) begin
                if (which != 0) sb24.push_back(e);
                else            sb16.push_back(e);
            end
            ch_model = (ch_model + 1) % 2;
        end
    endtask

    task automatic frame_start(input int which);
        @(posedge tb_clk_25mhz);
        #7;
        ch_model = 0;
        if (which != 0) act24 = 1'b1;
        else            act16 = 1'b1;
        #160;
    endtask

    task automatic frame_end(input int which);
        #160;
        if (which != 0) act24 = 1'b0;
        else            act16 = 1'b0;
        #320;
    endtask

    // Wait for a head word, compare it against the scoreboard, then pop it.
    task automatic pop_check(input int which, input string tag);
        exp_t        e;
        int          k;
        logic        v;
        logic [31:0] d;
        logic [31:0] c;
        k = 0;
        @(negedge tb_clk_25mhz);
        v = (which != 0) ? v24 : v16;
        while (!v && k < 200) begin
            @(negedge tb_clk_25mhz);
            k++;
            v = (which != 0) ? v24 : v16;
        end
        if (!v) begin
            check_val({tag, "_valid"}, {31'd0, v}, 32'd1);
            return;
        end
        if (((which != 0) ? sb24.size() : sb16.size()) == 0) begin
            check_val({tag, "_unexpected"}, {31'd0, v}, 32'd0);
            return;
        end
        if (which != 0) begin
            e = sb24.pop_front();
            d = 32'(data24);
            c = 32'(ch24);
        end else begin
            e = sb16.pop_front();
            d = 32'(data16);
            c = 32'(ch16);
        end
        check_val({tag, "_data"}, d, e.data);
        check_val({tag, "_ch"}, c, e.ch);
        if (which != 0) rdy24 = 1'b1;
        else            rdy16 = 1'b1;
        @(negedge tb_clk_25mhz);
        rdy16 = 1'b0;
        rdy24 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset    = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        act16    = 1'b0;
        act24    = 1'b0;
        rdy16    = 1'b0;
        rdy24    = 1'b0;
        ch_model = 0;

        // Reset state
        #30;
        check_val("rst_valid", {31'd0, v16}, 32'd0);
        check_val("rst_data",  32'(data16), 32'd0);
        check_val("rst_ch",    32'(ch16), 32'd0);
        check_val("rst_level", 32'(lvl16), 32'd0);
        check_val("rst_ferr",  {31'd0, fe16}, 32'd0);
        check_val("rst_ovr",   {31'd0, ov16}, 32'd0);
        repeat (3) @(posedge tb_clk_25mhz);
        #7;
        reset = 1'b0;
        wait_cycles(10);

        // Single word with latency measurement
        frame_start(0);
        send_word(0, 32'hC0DE, 16, 1'b1, 1'b1);
        frame_end(0);
        pop_check(0, "c0de");
        wait_cycles(2);
        check_val("c0de_level_after", 32'(lvl16), 32'd0);

        // Three interleaved words
        frame_start(0);
        send_word(0, 32'h1234, 16, 1'b1, 1'b0);
        send_word(0, 32'hABCD, 16, 1'b1, 1'b0);
        send_word(0, 32'h5555, 16, 1'b1, 1'b0);
        frame_end(0);
        pop_check(0, "w1234");
        pop_check(0, "wabcd");
        pop_check(0, "w5555");

        // Overrun: five words into a four-entry FIFO with no consumer
        frame_start(0);
        send_word(0, 32'h1001, 16, 1'b1, 1'b0);
        send_word(0, 32'h2002, 16, 1'b1, 1'b0);
        send_word(0, 32'h3003, 16, 1'b1, 1'b0);
        send_word(0, 32'h4004, 16, 1'b1, 1'b0);
        send_word(0, 32'h5005, 16, 1'b0, 1'b0);
        frame_end(0);
        wait_cycles(6);
        check_val("ovf_level", 32'(lvl16), 32'd4);
        check_val("ovf_flag",  {31'd0, ov16}, 32'd1);
        for (int i = 0; i < 4; i++) pop_check(0, "ovf_pop");
        wait_cycles(2);
        check_val("ovf_drained",  32'(lvl16), 32'd0);
        check_val("ovf_valid",    {31'd0, v16}, 32'd0);
        check_val("ovf_hold",     32'(data16), 32'h4004);
        check_val("ovf_sticky",   {31'd0, ov16}, 32'd1);

        // Aborted partial word after one complete word
        frame_start(0);
        send_word(0, 32'h7E81, 16, 1'b1, 1'b0);
        send_word(0, 32'h1FF, 9, 1'b0, 1'b0);
        #160;
        act16  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge tb_clk_25mhz);
            if (fe16) pulses++;
        end
        check_val("abort_pulses", pulses, 1);
        check_val("abort_level",  32'(lvl16), 32'd1);
        pop_check(0, "w7e81");
        frame_start(0);
        send_word(0, 32'hBEEF, 16, 1'b1, 1'b0);
        frame_end(0);
        pop_check(0, "wbeef");

        // Reset mid-frame with a word still buffered
        frame_start(0);
        send_word(0, 32'h3C3C, 16, 1'b0, 1'b0);
        wait_cycles(6);
        check_val("prerst_valid", {31'd0, v16}, 32'd1);
        send_word(0, 32'h55, 7, 1'b0, 1'b0);
        #5;
        reset = 1'b1;
        #1;
        check_val("midrst_valid", {31'd0, v16}, 32'd0);
        check_val("midrst_data",  32'(data16), 32'd0);
        check_val("midrst_level", 32'(lvl16), 32'd0);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(10);
        send_word(0, 32'hFFFF, 16, 1'b0, 1'b0);
        wait_cycles(10);
        check_val("postrst_ignored", 32'(lvl16), 32'd0);
        frame_end(0);
        frame_start(0);
        send_word(0, 32'h0F0F, 16, 1'b1, 1'b0);
        frame_end(0);
        pop_check(0, "w0f0f");

        // Wide word on the 24-bit instance
        frame_start(1);
        send_word(1, 32'hA5C3E1, 24, 1'b1, 1'b0);
        frame_end(1);
        pop_check(1, "wa5c3e1");

        wait_cycles(4);
        check_val("sb16_left", sb16.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
